// File: rtl/level_sequencer_if.sv
// Button/level-flag inputs and display/mux outputs of level_sequencer.
// skip_button exists only when SKIP_LEVEL_EN is defined.
interface level_sequencer_if;
  logic       start_button;
  logic       level_win;
  logic       level_lose;
`ifdef SKIP_LEVEL_EN
  logic       skip_button;
`endif
  logic [2:0] level_select;
  logic       level_reset;
  logic [2:0] lives;
  logic [7:0] seconds_left;
  logic [2:0] state;
  logic       game_over;
  logic       game_won;

  modport master (
    input  start_button, level_win, level_lose,
`ifdef SKIP_LEVEL_EN
    input  skip_button,
`endif
    output level_select, level_reset, lives, seconds_left, state, game_over, game_won
  );

  modport slave (
    output start_button, level_win, level_lose,
`ifdef SKIP_LEVEL_EN
    output skip_button,
`endif
    input  level_select, level_reset, lives, seconds_left, state, game_over, game_won
  );
endinterface

// File: rtl/level_sequencer.sv
// Game controller: picks the active level, runs its countdown and turns win/lose into advance/retry/game-over.
// Optional SKIP_LEVEL_EN adds a synchronised skip button that acts as a win while playing.
module level_sequencer #(
  parameter int NUM_LEVELS    = 4,
  parameter int START_LIVES   = 3,
  parameter int LEVEL_SECONDS = 99,
  parameter int CLOCK_HZ      = 25000000,
  parameter int HOLD_CYCLES   = 50000000
) (
  input  logic vga_clock,
  input  logic reset,
  level_sequencer_if.master bus
);

  localparam int unsigned DIV_W  = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCK_HZ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        LAST_LEVEL = 3'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    WIN_HOLD  = 3'd3,
    LOSE_HOLD = 3'd4,
    GAME_OVER = 3'd5,
    GAME_WON  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          level_q, level_d;
  logic [2:0]          lives_q, lives_d;
  logic [7:0]          secs_q, secs_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [1:0] start_sync;
  logic       start_prev;
  logic       start_edge;
  logic       win_event;

  // Synchroniser and history reset high so a button held through reset release yields no edge.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      start_sync <= '1;
      start_prev <= 1'b1;
    end else begin
      start_sync <= {start_sync[0], bus.start_button};
      start_prev <= start_sync[1];
    end
  end
  assign start_edge = start_sync[1] & ~start_prev;

`ifdef SKIP_LEVEL_EN
  logic [1:0] skip_sync;
  logic       skip_prev;
  logic       skip_edge;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      skip_sync <= '1;
      skip_prev <= 1'b1;
    end else begin
      skip_sync <= {skip_sync[0], bus.skip_button};
      skip_prev <= skip_sync[1];
    end
  end
  assign skip_edge = skip_sync[1] & ~skip_prev;
  assign win_event = bus.level_win | skip_edge;
`else
  assign win_event = bus.level_win;
`endif

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      lives_q <= 3'(START_LIVES);
      secs_q  <= 8'(LEVEL_SECONDS);
      div_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      secs_q  <= secs_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    secs_d  = secs_q;
    div_d   = '0;
    hold_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = LOAD;
      end
      LOAD: begin
        secs_d  = 8'(LEVEL_SECONDS);
        state_d = PLAY;
      end
      PLAY: begin
        if (div_q == DIV_LAST) begin
          if (secs_q != '0) secs_d = secs_q - 8'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (win_event)            state_d = WIN_HOLD;
        else if (bus.level_lose)  state_d = LOSE_HOLD;
        else if (secs_q == '0)    state_d = LOSE_HOLD;
      end
      WIN_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if (level_q == LAST_LEVEL) begin
            state_d = GAME_WON;
          end else begin
            level_d = level_q + 3'd1;
            state_d = LOAD;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LOSE_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? GAME_OVER : LOAD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      GAME_OVER, GAME_WON: begin
        if (start_edge) begin
          lives_d = 3'(START_LIVES);
          level_d = '0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.level_select = level_q;
  assign bus.level_reset  = (state_q == PLAY) || (state_q == WIN_HOLD) || (state_q == LOSE_HOLD);
  assign bus.lives        = lives_q;
  assign bus.seconds_left = secs_q;
  assign bus.state        = state_q;
  assign bus.game_over    = (state_q == GAME_OVER);
  assign bus.game_won     = (state_q == GAME_WON);

endmodule

// File: tb/tb_level_sequencer.sv
// Directed and randomized checks of level_sequencer against a game-level model
// (lives, level, countdown arithmetic) with CLOCK_HZ=10, HOLD_CYCLES=4, LEVEL_SECONDS=3.
module tb_level_sequencer;

  localparam int NUM_LEVELS = 2;
  localparam int START_LIVES = 2;
  localparam int LEVEL_SECONDS = 3;
  localparam int CLOCK_HZ = 10;
  localparam int HOLD_CYCLES = 4;

  localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_WIN_HOLD = 3,
                 S_LOSE_HOLD = 4, S_GAME_OVER = 5, S_GAME_WON = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_level;
  int   exp_lives;

  level_sequencer_if bus ();

  level_sequencer #(
    .NUM_LEVELS   (NUM_LEVELS),
    .START_LIVES  (START_LIVES),
    .LEVEL_SECONDS(LEVEL_SECONDS),
    .CLOCK_HZ     (CLOCK_HZ),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) dut (
    .vga_clock(clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_secs(input int k);
    int elapsed;
    elapsed = k / CLOCK_HZ;
    return (elapsed >= LEVEL_SECONDS) ? 0 : LEVEL_SECONDS - elapsed;
  endfunction

  task automatic wait_state(input string tag, input int st, input int budget);
    for (int i = 0; i < budget && int'(bus.state) != st; i++) tick();
    check(tag, bus.state, st);
  endtask

  task automatic press_start();
    bus.start_button = 1'b1;
    repeat (3) tick();
    bus.start_button = 1'b0;
    wait_state("start_to_load", S_LOAD, 6);
  endtask

  task automatic new_game();
    exp_lives = START_LIVES;
    exp_level = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, bus.state, S_IDLE);
    check({tag, "_level"}, bus.level_select, 0);
    check({tag, "_lives"}, bus.lives, START_LIVES);
    check({tag, "_secs"}, bus.seconds_left, LEVEL_SECONDS);
    check({tag, "_lvl_rst"}, bus.level_reset, 0);
    check({tag, "_over"}, bus.game_over, 0);
    check({tag, "_won"}, bus.game_won, 0);
  endtask

  task automatic do_reset();
    bus.start_button = 1'b0;
    bus.level_win = 1'b0;
    bus.level_lose = 1'b0;
`ifdef SKIP_LEVEL_EN
    bus.skip_button = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    new_game();
  endtask

  // From a LOAD sample: exactly one LOAD cycle, then PLAY with a fresh countdown.
  task automatic play_entry();
    check("load_state", bus.state, S_LOAD);
    check("load_lvl_rst", bus.level_reset, 0);
    check("load_lives", bus.lives, exp_lives);
    check("load_level", bus.level_select, exp_level);
    tick();
    check("play_state", bus.state, S_PLAY);
    check("play_lvl_rst", bus.level_reset, 1);
    check("play_secs", bus.seconds_left, LEVEL_SECONDS);
    check("play_level", bus.level_select, exp_level);
  endtask

  // One attempt from PLAY cycle 0. kind: 0 win, 1 lose, 2 win+lose, 3 timeout.
  task automatic attempt(input int kind, input int n);
    bit won;
    int st;
    won = (kind == 0) || (kind == 2);
    if (kind == 3) begin
      for (int k = 0; k <= LEVEL_SECONDS * CLOCK_HZ; k++) begin
        if (k % CLOCK_HZ == 0) check("countdown", bus.seconds_left, exp_secs(k));
        bus.start_button = (k >= 3 && k < 8);
        tick();
      end
      bus.start_button = 1'b0;
    end else begin
      repeat (n) tick();
      check("flag_secs", bus.seconds_left, exp_secs(n));
      check("flag_play", bus.state, S_PLAY);
      bus.level_win  = (kind != 1);
      bus.level_lose = (kind != 0);
      tick();
      bus.level_win  = 1'b0;
      bus.level_lose = 1'b0;
    end
    check("hold_entry", bus.state, won ? S_WIN_HOLD : S_LOSE_HOLD);
    check("hold_lives", bus.lives, exp_lives);
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      check("hold_state", bus.state, won ? S_WIN_HOLD : S_LOSE_HOLD);
      check("hold_lvl_rst", bus.level_reset, 1);
      bus.level_win  = (i < HOLD_CYCLES - 1) ? 1'($urandom) : 1'b0;
      bus.level_lose = (i < HOLD_CYCLES - 1) ? 1'($urandom) : 1'b0;
      tick();
    end
    if (won) begin
      if (exp_level == NUM_LEVELS - 1) st = S_GAME_WON;
      else begin exp_level++; st = S_LOAD; end
    end else begin
      if (exp_lives == 1) begin exp_lives = 0; st = S_GAME_OVER; end
      else begin exp_lives--; st = S_LOAD; end
    end
    check("after_state", bus.state, st);
    check("after_lives", bus.lives, exp_lives);
    check("after_level", bus.level_select, exp_level);
    check("after_lvl_rst", bus.level_reset, 0);
    check("after_over", bus.game_over, st == S_GAME_OVER);
    check("after_won", bus.game_won, st == S_GAME_WON);
  endtask

  initial begin
    bus.start_button = 1'b0;
    bus.level_win = 1'b0;
    bus.level_lose = 1'b0;
`ifdef SKIP_LEVEL_EN
    bus.skip_button = 1'b0;
`endif
    tick();
    check_reset_values("in_reset");
    do_reset();
    check_reset_values("post_reset");

    // Win both levels.
    press_start();
    play_entry();
    attempt(0, 5);
    play_entry();
    attempt(0, 12);

    // Restart from GAME_WON; simultaneous flags favour win, then two timeouts.
    press_start();
    new_game();
    play_entry();
    attempt(2, 0);
    play_entry();
    attempt(3, 0);
    play_entry();
    attempt(3, 0);

    // Restart from GAME_OVER, then reset in the middle of WIN_HOLD.
    press_start();
    new_game();
    play_entry();
    bus.level_win = 1'b1;
    tick();
    bus.level_win = 1'b0;
    check("pre_reset_hold", bus.state, S_WIN_HOLD);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    do_reset();

`ifdef SKIP_LEVEL_EN
    press_start();
    play_entry();
    bus.skip_button = 1'b1;
    repeat (3) tick();
    bus.skip_button = 1'b0;
    check("skip_win_hold", bus.state, S_WIN_HOLD);
    check("skip_lives", bus.lives, START_LIVES);
    do_reset();
`endif

    // Randomized attempts, restarting whenever the game ends.
    press_start();
    play_entry();
    for (int a = 0; a < 20; a++) begin
      int kind, n;
      kind = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, LEVEL_SECONDS * CLOCK_HZ));
      attempt(kind, n);
      if (int'(bus.state) == S_GAME_OVER || int'(bus.state) == S_GAME_WON) begin
        press_start();
        new_game();
      end
      play_entry();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
